torus_out_collector: RTL and testbench
======================================

// Module: torus_out_collector
// PURPOSE
//  Sits directly downstream of the 4x4 torus PE array and captures its four 16-bit row-0 outputs (data_out0..3) as one frame.
//  Frames are queued in a small FIFO, then serialised onto a single 16-bit valid/ready stream toward the host/readback logic.
//  The array can therefore run at full rate while the host drains results at its own pace.
// PARAMETERS
//  DW     16  lane width; matches the PE datapath width
//  DEPTH  8   frame FIFO depth in entries, each entry 4*DW bits; power of two, >= 2
// PORTS
//  clk         in   1            system clock; all logic on rising edge
//  rst         in   1            synchronous, active-high reset
//  cap_en      in   1            capture strobe: sample data_in0..3 at this edge
//  data_in0    in   DW           lane 0 (from torus data_out0)
//  data_in1    in   DW           lane 1 (from torus data_out1)
//  data_in2    in   DW           lane 2 (from torus data_out2)
//  data_in3    in   DW           lane 3 (from torus data_out3)
//  out_data    out  DW           serial beat, registered
//  out_valid   out  1            out_data holds a valid beat
//  out_ready   in   1            sink accepts the beat; transfer = out_valid & out_ready at an edge
//  out_last    out  1            marks the final beat of a frame
//  fifo_count  out  $clog2(DEPTH)+1  number of frames stored, including the one being sent
//  overflow    out  1            sticky: a capture was dropped
//  busy        out  1            high when fifo_count != 0 or out_valid
// BEHAVIOUR
//  Reset (rst=1 at an edge) has priority over every other event:
//   - out_data=0, out_valid=0, out_last=0, fifo_count=0, overflow=0;
//   - rd/wr pointers=0, beat counter=0, FSM=IDLE.
//   - Applied mid-frame, it discards the partial frame and all queued frames; no beat is emitted after it.
//  Capture:
//   - cap_en=1 and not full: entry {in3,in2,in1,in0} written at wr_ptr; wr_ptr++ (wraps DEPTH-1 -> 0); count++.
//   - Full (fifo_count==DEPTH) with cap_en=1: frame dropped and overflow<=1. overflow clears only on reset.
//   - Exception: if the last beat of the head frame transfers at that same edge, the capture is accepted and count is unchanged.
//  FSM states:
//   - IDLE: out_valid=0. When fifo_count!=0, load lane0 of the head entry into out_data, out_valid<=1, beat<=0 -> SEND.
//   - SEND: out_data/out_valid/out_last held stable while out_valid & !out_ready.
//     On a transfer that is not the last beat: beat++, out_data<=next lane.
//     On a transfer of the last beat: pop the head (rd_ptr++, count--).
//       - If a further frame was already stored before this edge: load its lane0 with no bubble, stay in SEND.
//       - Otherwise: out_valid<=0 -> IDLE.
//  Latency: cap_en at edge N into an empty, idle block -> lane0 visible with out_valid=1 after edge N+1.
//  A capture landing at the same edge as the final pop into an otherwise empty FIFO produces exactly one idle cycle, then is sent.
//  Lanes are sent in order 0,1,2,3; data is passed through unmodified (no arithmetic).
//  Simultaneous capture and pop: count is unchanged.
// CONFIGURATION
//  TORUS_OUTCOL_XSUM_EN
//   - Defined: each frame is 5 beats: lanes 0..3, then checksum = in0^in1^in2^in3 (DW-bit XOR); out_last=1 on beat 4 only.
//   - Undefined: each frame is 4 beats; out_last=1 on lane 3; no checksum logic is synthesised.
// TESTING
//  T1 reset then single capture of 0x1111/0x2222/0x3333/0x4444, out_ready=1
//     -> beats 0x1111,0x2222,0x3333,0x4444 on 4 consecutive cycles starting after edge N+1; last beat has out_last=1;
//        with XSUM: a 5th beat 0x4444 with out_last=1; then fifo_count=0 and busy=0.
//  T2 out_ready held 0 for 5 cycles mid-frame
//     -> out_data/out_valid/out_last stay constant; no beat is lost or duplicated after out_ready rises.
//  T3 DEPTH+2 back-to-back captures with out_ready=0
//     -> fifo_count saturates at 8, overflow=1, the first 8 frames drain intact, and the last 2 frames never appear.
//  T4 two frames queued, out_ready=1
//     -> the second frame's lane0 follows the first frame's last beat with no bubble.
//     Full FIFO plus a capture at the last-beat edge -> capture accepted, overflow stays 0.
//  T5 assert rst during beat 2 with 3 frames queued
//     -> next cycle out_valid=0, fifo_count=0, overflow=0.
//     A fresh capture afterwards is emitted normally starting from lane0.

Source files
------------

// File: rtl/torus_out_collector.sv
`default_nettype none
// ============================================================================
// Module   : torus_out_collector
// Purpose  : Captures the four row-0 lanes of the 4x4 torus PE array as one
//            frame, queues frames in a small FIFO and serialises them onto a
//            single DW-bit valid/ready stream (lane 0 first).
// Ports    : clk, rst (sync, active high)
//            cap_en, data_in0..3    - capture strobe and the four lanes
//            out_data/out_valid/out_last, out_ready - serial output stream
//            fifo_count             - frames stored, including the one in flight
//            overflow               - sticky, a capture was dropped
//            busy                   - frames stored or a beat pending
// Config   : TORUS_OUTCOL_XSUM_EN   - append an XOR checksum beat to each frame
// Revision : 1.0 - initial release
// ============================================================================
module torus_out_collector #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic [DW-1:0]            data_in0,
    input  logic [DW-1:0]            data_in1,
    input  logic [DW-1:0]            data_in2,
    input  logic [DW-1:0]            data_in3,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL  = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]   c_ONE   = (c_AW+1)'(1);
`ifdef TORUS_OUTCOL_XSUM_EN
    localparam logic [2:0]      c_LAST_BEAT = 3'd4;
`else
    localparam logic [2:0]      c_LAST_BEAT = 3'd3;
`endif
    localparam logic [0:0]      c_IDLE  = 1'b0;
    localparam logic [0:0]      c_SEND  = 1'b1;

    logic [4*DW-1:0] r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] w_rd_ptr_inc;
    logic [c_AW:0]   r_count;
    logic [2:0]      r_beat;
    logic [2:0]      w_beat_nxt;
    logic [2:0]      w_beat_inc;
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [DW-1:0]   r_out_data;
    logic [DW-1:0]   w_data_nxt;
    logic            r_out_valid;
    logic            w_valid_nxt;
    logic            r_out_last;
    logic            w_last_nxt;
    logic            r_overflow;
    logic            w_xfer;
    logic            w_last_xfer;
    logic            w_full;
    logic            w_wr;
    logic            w_drop;
    logic [4*DW-1:0] w_head;
    logic [4*DW-1:0] w_next_head;

    // Selects beat idx of a stored frame; the checksum beat exists only when
    // the checksum feature is built in.
    function automatic logic [DW-1:0] f_lane(input logic [4*DW-1:0] e,
                                             input logic [2:0]      idx);
        case (idx)
            3'd0:    f_lane = e[DW-1:0];
            3'd1:    f_lane = e[2*DW-1:DW];
            3'd2:    f_lane = e[3*DW-1:2*DW];
`ifdef TORUS_OUTCOL_XSUM_EN
            3'd3:    f_lane = e[4*DW-1:3*DW];
            default: f_lane = e[DW-1:0] ^ e[2*DW-1:DW] ^ e[3*DW-1:2*DW] ^ e[4*DW-1:3*DW];
`else
            default: f_lane = e[4*DW-1:3*DW];
`endif
        endcase
    endfunction

    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
    assign w_beat_inc   = r_beat + 3'd1;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_next_head  = r_mem[w_rd_ptr_inc];
    assign w_full       = (r_count == c_FULL);
    assign w_xfer       = (r_state == c_SEND) && r_out_valid && out_ready;
    assign w_last_xfer  = w_xfer && (r_beat == c_LAST_BEAT);
    // A full FIFO still accepts a capture when its head frame retires at the
    // same edge: the freed slot is the one being written.
    assign w_wr         = cap_en && (!w_full || w_last_xfer);
    assign w_drop       = cap_en && w_full && !w_last_xfer;

    // Frame storage (no reset needed: pointers qualify every read)
    always_ff @(posedge clk) begin
        if (w_wr && !rst) begin
            r_mem[r_wr_ptr] <= {data_in3, data_in2, data_in1, data_in0};
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)        r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_last_xfer) r_rd_ptr <= w_rd_ptr_inc;
            if (w_wr && !w_last_xfer)      r_count <= r_count + c_ONE;
            else if (!w_wr && w_last_xfer) r_count <= r_count - c_ONE;
            if (w_drop)      r_overflow <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (r_count != '0) w_state_nxt = c_SEND;
            c_SEND:  if (w_last_xfer && r_count == c_ONE) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered stream outputs
    always_comb begin
        w_data_nxt  = r_out_data;
        w_valid_nxt = r_out_valid;
        w_last_nxt  = r_out_last;
        w_beat_nxt  = r_beat;
        case (r_state)
            c_IDLE: begin
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                if (r_count != '0) begin
                    w_data_nxt  = f_lane(w_head, 3'd0);
                    w_valid_nxt = 1'b1;
                    w_beat_nxt  = 3'd0;
                end
            end
            c_SEND: begin
                if (w_xfer) begin
                    if (r_beat != c_LAST_BEAT) begin
                        w_beat_nxt = w_beat_inc;
                        w_data_nxt = f_lane(w_head, w_beat_inc);
                        w_last_nxt = (w_beat_inc == c_LAST_BEAT);
                    end else if (r_count > c_ONE) begin
                        // Next frame was already queued: back-to-back, no bubble
                        w_beat_nxt = 3'd0;
                        w_data_nxt = f_lane(w_next_head, 3'd0);
                        w_last_nxt = 1'b0;
                    end else begin
                        w_beat_nxt  = 3'd0;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    // Registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_beat      <= 3'd0;
        end else begin
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_last  <= w_last_nxt;
            r_beat      <= w_beat_nxt;
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign busy       = (r_count != '0) || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_torus_out_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_torus_out_collector
// Purpose  : Scoreboard bench for torus_out_collector. The driver keeps a
//            frame-level model (occupancy, sticky drop flag, expected beat
//            queue); the monitor pops and compares every transferred beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_torus_out_collector;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
`ifdef TORUS_OUTCOL_XSUM_EN
    localparam int c_BEATS = 5;
`else
    localparam int c_BEATS = 4;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cap_en = 1'b0;
    logic [DW-1:0]          data_in0 = '0;
    logic [DW-1:0]          data_in1 = '0;
    logic [DW-1:0]          data_in2 = '0;
    logic [DW-1:0]          data_in3 = '0;
    logic                   out_ready = 1'b0;
    logic [DW-1:0]          out_data;
    logic                   out_valid;
    logic                   out_last;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic                   busy;

    beat_t   sb[$];
    int      checks      = 0;
    int      failures    = 0;
    int      model_count = 0;
    bit      model_ovf   = 1'b0;

    bit            hold_pend = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    torus_out_collector #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .data_in0   (data_in0),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [4*DW-1:0] rand_frame();
        logic [4*DW-1:0] f;
        f = {$urandom, $urandom};
        return f;
    endfunction

    // Expected beats of one frame: lanes in order, optional XOR checksum
    task automatic push_frame(input logic [4*DW-1:0] f);
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{data: f[i*DW +: DW], last: (i == c_BEATS - 1)});
            x = x ^ f[i*DW +: DW];
        end
        if (c_BEATS == 5) sb.push_back('{data: x, last: 1'b1});
    endtask

    task automatic check_status();
        chk("fifo_count", 32'(fifo_count), 32'(model_count));
        chk("overflow", 32'(overflow), 32'(model_ovf));
        chk("busy", 32'(busy), 32'(model_count != 0));
        if (model_count == 0) chk("valid_when_empty", 32'(out_valid), 32'd0);
    endtask

    // One clock: wait for the edge, check status, then drive inputs for the
    // next edge and advance the model by what that edge will do.
    task automatic step(input bit cap, input bit rdy, input bit rs,
                        input bit cap_on_last, input logic [4*DW-1:0] f);
        bit c, pop, acc;
        @(posedge clk);
        #1;
        check_status();
        c         = cap_on_last ? (out_last === 1'b1) : cap;
        rst       = rs;
        out_ready = rs ? 1'b0 : rdy;
        cap_en    = c;
        data_in0  = f[DW-1:0];
        data_in1  = f[2*DW-1:DW];
        data_in2  = f[3*DW-1:2*DW];
        data_in3  = f[4*DW-1:3*DW];
        if (rs) begin
            sb.delete();
            model_count = 0;
            model_ovf   = 1'b0;
        end else begin
            pop = (out_valid === 1'b1) && out_ready && (sb.size() > 0) && sb[0].last;
            acc = c && ((model_count < DEPTH) || pop);
            if (acc) push_frame(f);
            if (c && !acc) model_ovf = 1'b1;
            model_count = model_count + int'(acc) - int'(pop);
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 1'b0, rand_frame());
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, rand_frame());
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        idle(2, 1'b1);
    endtask

    // Monitor: every transfer must match the head of the expected queue;
    // a stalled beat must be presented unchanged on the next cycle.
    always @(negedge clk) begin
        beat_t e;
        if (hold_pend) begin
            hold_pend = 1'b0;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(hold_data));
            chk("hold_last", 32'(out_last), 32'(hold_last));
        end
        if (!rst && out_valid === 1'b1) begin
            if (out_ready) begin
                chk("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat_data", 32'(out_data), 32'(e.data));
                    chk("beat_last", 32'(out_last), 32'(e.last));
                end
            end else begin
                hold_pend = 1'b1;
                hold_data = out_data;
                hold_last = out_last;
            end
        end
    end

    initial begin
        int run;
        bit seen;
        int cp, rp;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);

        // Single frame, capture-to-lane0 latency
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'h4444_3333_2222_1111);
        step(1'b0, 1'b1, 1'b0, 1'b0, rand_frame());
        chk("t1_valid_after_n", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, rand_frame());
        chk("t1_valid_after_n1", 32'(out_valid), 32'd1);
        chk("t1_lane0", 32'(out_data), 32'h1111);
        drain();

        // Stall for 5 cycles mid-frame
        step(1'b1, 1'b1, 1'b0, 1'b0, rand_frame());
        idle(3, 1'b1);
        idle(5, 1'b0);
        drain();

        // Two queued frames go out back to back
        step(1'b1, 1'b1, 1'b0, 1'b0, rand_frame());
        step(1'b1, 1'b1, 1'b0, 1'b0, rand_frame());
        run  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, rand_frame());
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                run++;
            end else if (seen) begin
                break;
            end
        end
        chk("t4_no_bubble", 32'(run), 32'(2 * c_BEATS));
        drain();

        // Full FIFO plus capture at the last-beat edge is accepted
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rand_frame());
        idle(2, 1'b0);
        for (int i = 0; i < c_BEATS; i++) step(1'b0, 1'b1, 1'b0, 1'b1, rand_frame());
        step(1'b0, 1'b0, 1'b0, 1'b0, rand_frame());
        chk("t4_full_accept_ovf", 32'(overflow), 32'd0);
        chk("t4_full_accept_cnt", 32'(fifo_count), 32'(DEPTH));
        drain();

        // Overflow: DEPTH+2 captures with the sink stalled
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rand_frame());
        step(1'b0, 1'b0, 1'b0, 1'b0, rand_frame());
        chk("t3_count_sat", 32'(fifo_count), 32'(DEPTH));
        chk("t3_overflow", 32'(overflow), 32'd1);
        drain();

        // Reset during beat 2 with three frames queued
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rand_frame());
        idle(2, 1'b0);
        idle(2, 1'b1);
        chk("t5_midframe", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, rand_frame());
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_count", 32'(fifo_count), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, rand_frame());
        drain();

        // Randomised traffic at several capture/ready mixes
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0:       begin cp = 40; rp = 60; end
                1:       begin cp = 80; rp = 20; end
                2:       begin cp = 20; rp = 90; end
                default: begin cp = 60; rp = 50; end
            endcase
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(0, 99) < cp, $urandom_range(0, 99) < rp,
                     $urandom_range(0, 399) == 0, 1'b0, rand_frame());
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
